instruction_fetch_unit: RTL and testbench

//  Upstream fetch stage for single_cycle_processor: owns the PC, reads a word-addressed

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/instr_rom.sv | 23 ++
 rtl/instruction_fetch_unit.sv | 133 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [5:0]  OP_J      = 6'b000010;
    localparam logic [5:0]  OP_BEQ    = 6'b000100;
    localparam logic [31:0] PC_INC    = 32'd4;

    // beq displacement: sign-extended word offset converted to bytes
    function automatic logic [31:0] branch_disp(input logic [15:0] offset);
        return {{14{offset[15]}}, offset, 2'b00};
    endfunction

endpackage

// File: rtl/instr_rom.sv
// Read-only instruction memory with a combinational read port.
// Contents come from INIT_IMAGE.
module instr_rom #(
    parameter int                      IMEM_DEPTH = 64,
    parameter string                   INIT_FILE  = "imem.hex",
    parameter logic [32*IMEM_DEPTH-1:0] INIT_IMAGE = '0,
    parameter int                      ADDR_W     = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [31:0]       data
);

    logic [31:0] mem [IMEM_DEPTH];

    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            mem[i] = INIT_IMAGE[32*i +: 32];
        end
    end

    assign data = mem[addr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, applies jump/branch redirects, registers one
// instruction per cycle, and latches a sticky fault on out-of-range fetches.
//
//   state | meaning
//   BOOT  | first edge after reset: load instruction at RESET_PC
//   RUN   | normal fetch, one instruction per unstalled edge
//   FAULT | next PC left the ROM; outputs frozen until reset
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                       IMEM_DEPTH = 64,
    parameter logic [31:0]              RESET_PC   = 32'h0000_0000,
    parameter string                    INIT_FILE  = "imem.hex",
    parameter logic [32*IMEM_DEPTH-1:0] INIT_IMAGE = '0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    output logic        fault,
    output logic [31:0] fetch_count
);

    localparam int          AW       = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_DEPTH);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         valid_q, valid_d;
    logic         fault_q, fault_d;
    logic [31:0]  count_q, count_d;

    logic [31:0]  seq_pc;
    logic [31:0]  next_pc;
    logic         next_in_range;
    logic [AW-1:0] rom_addr;
    logic [31:0]  rom_data;

    instr_rom #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .INIT_FILE  (INIT_FILE),
        .INIT_IMAGE (INIT_IMAGE),
        .ADDR_W     (AW)
    ) u_rom (
        .addr (rom_addr),
        .data (rom_data)
    );

    // Redirect priority: jump over taken branch over sequential.
    // Unsigned compare also catches branches that wrap below zero.
    always_comb begin
        seq_pc = pc_q + PC_INC;
        if (jump) begin
            next_pc = {seq_pc[31:28], jump_target, 2'b00};
        end else if (branch_taken) begin
            next_pc = seq_pc + branch_disp(branch_offset);
        end else begin
            next_pc = seq_pc;
        end
        next_in_range = (next_pc < PC_LIMIT);
        rom_addr      = (state_q == BOOT) ? AW'(RESET_PC >> 2) : AW'(next_pc >> 2);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        fault_d = fault_q;
        count_d = count_q;
        case (state_q)
            BOOT: begin
                instr_d = rom_data;
                valid_d = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (!stall) begin
                    if (next_in_range) begin
                        pc_d    = next_pc;
                        instr_d = rom_data;
                        count_d = count_q + 32'd1;
                    end else begin
                        state_d = FAULT;
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                        fault_d = 1'b1;
                    end
                end
            end
            FAULT: begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
                fault_d = 1'b1;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    assign instruction = instr_q;
    assign pc_out      = pc_q;
    assign instr_valid = valid_q;
    assign fault       = fault_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed sequence then random redirects/stalls/resets.
module tb_instruction_fetch_unit;

    localparam int          DEPTH = 8;
    localparam logic [31:0] RST_PC = 32'h0;
    localparam logic [32*DEPTH-1:0] IMAGE = {
        32'h0, 32'h0, 32'h0, 32'h0800_0004,
        32'h114A_0002, 32'hAD4A_0008, 32'h8D4A_0004, 32'h014A_4020};

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        fault;
    logic [31:0] fetch_count;

    instruction_fetch_unit #(
        .IMEM_DEPTH (DEPTH),
        .RESET_PC   (RST_PC),
        .INIT_FILE  (""),
        .INIT_IMAGE (IMAGE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .instruction   (instruction),
        .pc_out        (pc_out),
        .instr_valid   (instr_valid),
        .fault         (fault),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        flt;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: program image plus abstract fetch status
    logic [31:0] img_m [DEPTH] = '{32'h014A4020, 32'h8D4A0004, 32'hAD4A0008,
                                   32'h114A0002, 32'h08000004, 32'h0, 32'h0, 32'h0};
    bit          m_booted;
    bit          m_faulted;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    function automatic void model_reset();
        m_booted  = 0;
        m_faulted = 0;
        m_pc      = RST_PC;
        m_cnt     = 0;
    endfunction

    function automatic void model_edge();
        longint seq, np;
        if (!reset) begin
            model_reset();
        end else if (!m_booted) begin
            m_booted = 1;
        end else if (!m_faulted && !stall) begin
            seq = (longint'(m_pc) + 4) & 64'hFFFF_FFFF;
            if (jump)
                np = (seq & 64'hF000_0000) + longint'(jump_target) * 4;
            else if (branch_taken)
                np = (seq + 4 * longint'($signed(branch_offset))) & 64'hFFFF_FFFF;
            else
                np = seq;
            if (np >= 4 * DEPTH) begin
                m_faulted = 1;
            end else begin
                m_pc  = np[31:0];
                m_cnt = m_cnt + 1;
            end
        end
    endfunction

    function automatic void push_expected();
        exp_t e;
        e.pc    = m_pc;
        e.valid = m_booted && !m_faulted;
        e.instr = e.valid ? img_m[m_pc[4:2]] : 32'h0;
        e.flt   = m_faulted;
        e.cnt   = m_cnt;
        sb.push_back(e);
    endfunction

    task automatic tick(input bit rst_mid);
        @(posedge clk);
        #1;
        model_edge();
        if (rst_mid) begin
            reset = 1'b0;
            model_reset();
        end
        push_expected();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare the DUT against the oldest pending expectation each cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc_out",      pc_out,              e.pc);
                chk("instruction", instruction,         e.instr);
                chk("instr_valid", {31'b0, instr_valid}, {31'b0, e.valid});
                chk("fault",       {31'b0, fault},       {31'b0, e.flt});
                chk("fetch_count", fetch_count,         e.cnt);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_offset = '0;
        jump = 1'b0; jump_target = '0;
        model_reset();

        // reset, boot, sequential fetch
        tick(0); tick(0);
        reset = 1'b1;
        tick(0);
        tick(0); tick(0); tick(0);
        // taken beq at 0x0C
        branch_taken = 1'b1; branch_offset = 16'h0002;
        tick(0);
        branch_taken = 1'b0;
        // jump back to 0x10
        jump = 1'b1; jump_target = 26'h4;
        tick(0);
        // jump and branch together
        jump_target = 26'h1; branch_taken = 1'b1;
        tick(0);
        branch_taken = 1'b0;
        // stalled redirect, then released
        stall = 1'b1; jump_target = 26'h3;
        tick(0); tick(0); tick(0);
        stall = 1'b0;
        tick(0);
        jump = 1'b0;
        // run off the end of the ROM
        for (int k = 0; k < 6; k++) tick(0);
        stall = 1'b1;
        tick(0);
        stall = 1'b0;
        // asynchronous reset between edges, then reboot
        tick(1);
        tick(0);
        reset = 1'b1;
        tick(0); tick(0);

        // random phase
        for (int n = 0; n < 3000; n++) begin
            bit rst_mid;
            rst_mid = reset && ($urandom_range(0, 99) < (m_faulted ? 15 : 2));
            tick(rst_mid);
            if (!reset && !rst_mid && $urandom_range(0, 1) == 1) reset = 1'b1;
            stall        = ($urandom_range(0, 3) == 0);
            jump         = ($urandom_range(0, 6) == 0);
            branch_taken = ($urandom_range(0, 4) == 0);
            jump_target  = ($urandom_range(0, 19) == 0) ? 26'($urandom) : 26'($urandom_range(0, 9));
            branch_offset = ($urandom_range(0, 19) == 0) ? 16'($urandom)
                                                         : 16'(int'($urandom_range(0, 12)) - 6);
        end

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
